usb_tx_sequencer: RTL and testbench



---
 rtl/usb_tx_sequencer_if.sv | 30 +++
 rtl/usb_tx_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_usb_tx_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/usb_tx_sequencer_if.sv
// Bundle between the protocol layer / TX FIFO, the transmit sequencer
// and the serialiser / NRZI encoder.
interface usb_tx_if;
    logic [2:0]  tx_packet;
    logic [6:0]  buffer_occupancy;
    logic [7:0]  tx_packet_data;
    logic [15:0] crc16_in;
    logic        stuff_hold;
    logic [7:0]  shift_byte;
    logic        load_byte;
    logic        bit_strobe;
    logic        eop_se0;
    logic        get_tx_packet_data;
    logic        tx_transfer_active;
    logic        tx_error;

    modport master (
        output tx_packet, buffer_occupancy, tx_packet_data,
        output crc16_in, stuff_hold,
        input  shift_byte, load_byte, bit_strobe, eop_se0,
        input  get_tx_packet_data, tx_transfer_active, tx_error
    );

    modport slave (
        input  tx_packet, buffer_occupancy, tx_packet_data,
        input  crc16_in, stuff_hold,
        output shift_byte, load_byte, bit_strobe, eop_se0,
        output get_tx_packet_data, tx_transfer_active, tx_error
    );
endinterface

// File: rtl/usb_tx_sequencer.sv
// Full-speed USB transmit control FSM: sequences SYNC, PID, payload,
// CRC16 and EOP onto the serialiser, owning bit timing and FIFO pops.
module usb_tx_sequencer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_PAYLOAD  = 64
) (
    input logic     clk,
    input logic     rst,
    usb_tx_if.slave bus
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [6:0] MAXB = 7'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP, J_IDLE
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_cnt;
    logic [6:0]    byte_cnt;
    logic [2:0]    pkt;
    logic          load;
    logic          pop;
    logic          se0;
    logic          active;
    logic          err;
    logic [7:0]    byte_q;
    logic [7:0]    byte_src;
    logic [7:0]    pid;
    logic          strobe;
    logic          byte_state;
    logic          bit_done;
    logic          handshake;
    logic          data_req;
    logic          valid_req;
    logic          too_big;
    logic          has_data;

    assign strobe     = (state != IDLE) && (timer == LAST);
    assign byte_state = state inside {SYNC, PID, DATA, CRC_LO, CRC_HI};
    assign bit_done   = strobe && byte_state && !bus.stuff_hold;
    assign handshake  = pkt inside {3'd3, 3'd4, 3'd5};
    assign data_req   = bus.tx_packet inside {3'd1, 3'd2};
    assign valid_req  = bus.tx_packet inside {[3'd1:3'd5]};
    assign too_big    = data_req && (bus.buffer_occupancy > MAXB);
    assign has_data   = bus.buffer_occupancy != 7'd0;

    always_comb begin
        pid = 8'h00;
        case (pkt)
            3'd1:    pid = 8'hC3;
            3'd2:    pid = 8'h4B;
            3'd3:    pid = 8'hD2;
            3'd4:    pid = 8'h5A;
            3'd5:    pid = 8'h1E;
            default: pid = 8'h00;
        endcase
    end

    // Payload and CRC bytes are taken live in the load cycle
    always_comb begin
        byte_src = byte_q;
        case (state)
            SYNC:    byte_src = 8'h80;
            PID:     byte_src = pid;
            DATA:    byte_src = bus.tx_packet_data;
            CRC_LO:  byte_src = bus.crc16_in[7:0];
            CRC_HI:  byte_src = bus.crc16_in[15:8];
            default: byte_src = byte_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            pkt      <= '0;
            load     <= 1'b0;
            pop      <= 1'b0;
            se0      <= 1'b0;
            active   <= 1'b0;
            err      <= 1'b0;
            byte_q   <= '0;
        end else begin
            load <= 1'b0;
            pop  <= 1'b0;
            err  <= 1'b0;
            if (load) byte_q <= byte_src;
            if (state != IDLE) timer <= strobe ? '0 : timer + 1'b1;
            case (state)
                IDLE: begin
                    if (valid_req && !too_big) begin
                        state    <= SYNC;
                        load     <= 1'b1;
                        active   <= 1'b1;
                        pkt      <= bus.tx_packet;
                        byte_cnt <= '0;
                        bit_cnt  <= '0;
                        timer    <= '0;
                    end else if (bus.tx_packet[2:1] == 2'b11 || too_big) begin
                        err <= 1'b1;
                    end
                end
                EOP: begin
                    if (strobe) begin
                        if (bit_cnt == 3'd1) begin
                            state   <= J_IDLE;
                            se0     <= 1'b0;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                J_IDLE: begin
                    if (strobe) begin
                        state  <= IDLE;
                        active <= 1'b0;
                    end
                end
                default: begin
                    if (bit_done) begin
                        if (bit_cnt != 3'd7) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end else begin
                            bit_cnt <= '0;
                            case (state)
                                SYNC: begin
                                    state <= PID;
                                    load  <= 1'b1;
                                end
                                PID: begin
                                    if (handshake) begin
                                        state <= EOP;
                                        se0   <= 1'b1;
                                    end else if (has_data) begin
                                        state    <= DATA;
                                        load     <= 1'b1;
                                        pop      <= 1'b1;
                                        byte_cnt <= byte_cnt + 1'b1;
                                    end else begin
                                        state <= CRC_LO;
                                        load  <= 1'b1;
                                    end
                                end
                                DATA: begin
                                    if (has_data && byte_cnt < MAXB) begin
                                        load     <= 1'b1;
                                        pop      <= 1'b1;
                                        byte_cnt <= byte_cnt + 1'b1;
                                    end else begin
                                        // leftover bytes mean the payload limit cut the packet
                                        state <= CRC_LO;
                                        load  <= 1'b1;
                                        err   <= has_data;
                                    end
                                end
                                CRC_LO: begin
                                    state <= CRC_HI;
                                    load  <= 1'b1;
                                end
                                default: begin
                                    state <= EOP;
                                    se0   <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign bus.shift_byte         = load ? byte_src : byte_q;
    assign bus.load_byte          = load;
    assign bus.bit_strobe         = strobe;
    assign bus.eop_se0            = se0;
    assign bus.get_tx_packet_data = pop;
    assign bus.tx_transfer_active = active;
    assign bus.tx_error           = err;
endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Bench for usb_tx_sequencer: a packet-level model predicts every
// output cycle by cycle from byte lists and bit-period arithmetic.
module tb_usb_tx_sequencer;
    localparam int CPB  = 8;
    localparam int MAXP = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] held = 8'h00;
    logic [7:0] preset[$];
    logic [7:0] fifo[$];
    int         vectors = 0;
    int         miscompares = 0;

    usb_tx_if bus ();

    usb_tx_sequencer #(
        .CLKS_PER_BIT(CPB),
        .MAX_PAYLOAD (MAXP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pid_of(input int code);
        case (code)
            1:       return 8'hC3;
            2:       return 8'h4B;
            3:       return 8'hD2;
            4:       return 8'h5A;
            5:       return 8'h1E;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input int cyc,
                       input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic check_cycle(input int cyc, input logic el,
                               input logic [7:0] eb, input logic eg,
                               input logic ese, input logic eact,
                               input logic estr, input logic eerr);
        chk("load_byte", cyc, 16'(bus.load_byte), 16'(el));
        chk("shift_byte", cyc, 16'(bus.shift_byte), 16'(eb));
        chk("get_tx_packet_data", cyc, 16'(bus.get_tx_packet_data), 16'(eg));
        chk("eop_se0", cyc, 16'(bus.eop_se0), 16'(ese));
        chk("tx_transfer_active", cyc, 16'(bus.tx_transfer_active), 16'(eact));
        chk("bit_strobe", cyc, 16'(bus.bit_strobe), 16'(estr));
        chk("tx_error", cyc, 16'(bus.tx_error), 16'(eerr));
    endtask

    task automatic drive_fifo();
        bus.buffer_occupancy = 7'(fifo.size());
        bus.tx_packet_data   = (fifo.size() > 0) ? fifo[0] : 8'h00;
    endtask

    task automatic run_packet(input int code, input int occ, input int extra,
                              input logic [15:0] crc, input bit stuff_rand,
                              input int stuff_period, input int abort_at);
        logic [7:0] all[$];
        logic [7:0] exp_b[$];
        int         exp_c[$];
        bit         mask[4096];
        int         total, n, p, need, eop_start, end_cyc, err_cyc, li, idx;
        bit         pop;
        logic       el, eg, ese, eact, estr, eerr;
        total = occ + extra;
        fifo.delete();
        for (int i = 0; i < total; i++)
            all.push_back(preset.size() > 0 ? preset.pop_front() : 8'($urandom));
        for (int i = 0; i < occ; i++) fifo.push_back(all[i]);
        exp_b.push_back(8'h80);
        exp_b.push_back(pid_of(code));
        n = 0;
        if (code <= 2) begin
            n = (total > MAXP) ? MAXP : total;
            for (int i = 0; i < n; i++) exp_b.push_back(all[i]);
            exp_b.push_back(crc[7:0]);
            exp_b.push_back(crc[15:8]);
        end
        for (int i = 0; i < 4096; i++)
            mask[i] = (i < 1500) && stuff_rand && ($urandom_range(0, 7) == 0);
        if (stuff_period >= 0) mask[stuff_period] = 1'b1;
        // a byte spans 8 unstuffed bit periods; stuffed periods stretch it
        p = 0;
        foreach (exp_b[i]) begin
            exp_c.push_back(1 + p * CPB);
            need = 8;
            while (need > 0) begin
                if (!mask[p]) need--;
                p++;
            end
        end
        eop_start = 1 + p * CPB;
        end_cyc   = (p + 3) * CPB + 1;
        err_cyc   = (code <= 2 && total > MAXP) ? exp_c[2 + n] : -1;

        bus.tx_packet  = 3'(code);
        bus.crc16_in   = crc;
        bus.stuff_hold = 1'b0;
        drive_fifo();
        li  = 0;
        pop = 1'b0;
        for (int cyc = 1; cyc <= end_cyc; cyc++) begin
            @(posedge clk);
            #1;
            if (pop) begin
                if (fifo.size() > 0) void'(fifo.pop_front());
                pop = 1'b0;
            end
            if (cyc == 1)
                for (int i = occ; i < total; i++) fifo.push_back(all[i]);
            drive_fifo();
            if (cyc == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                fifo.delete();
                drive_fifo();
                bus.tx_packet  = 3'd0;
                bus.stuff_hold = 1'b0;
                held = 8'h00;
                check_cycle(-1, 1'b0, held, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            idx = li;
            el  = (li < exp_c.size()) && (exp_c[li] == cyc);
            if (el) begin
                held = exp_b[li];
                li++;
            end
            eg   = el && idx >= 2 && idx < 2 + n;
            ese  = (cyc >= eop_start) && (cyc < eop_start + 2 * CPB);
            eact = cyc < end_cyc;
            estr = eact && (cyc % CPB == 0);
            eerr = cyc == err_cyc;
            check_cycle(cyc, el, held, eg, ese, eact, estr, eerr);
            if (bus.get_tx_packet_data) pop = 1'b1;
            bus.tx_packet  = (cyc < end_cyc) ? 3'($urandom_range(0, 7)) : 3'd0;
            bus.stuff_hold = (cyc < end_cyc) ? mask[(cyc - 1) / CPB] : 1'b0;
        end
    endtask

    task automatic run_err(input int code, input int occ);
        fifo.delete();
        bus.tx_packet        = 3'(code);
        bus.buffer_occupancy = 7'(occ);
        bus.tx_packet_data   = 8'($urandom);
        @(posedge clk);
        #1;
        check_cycle(1, 1'b0, held, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.tx_packet = 3'd0;
        @(posedge clk);
        #1;
        check_cycle(2, 1'b0, held, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.tx_packet        = 3'd0;
        bus.buffer_occupancy = 7'd0;
        bus.tx_packet_data   = 8'h00;
        bus.crc16_in         = 16'h0000;
        bus.stuff_hold       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_cycle(0, 1'b0, held, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_cycle(0, 1'b0, held, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        run_packet(3, 0, 0, 16'h0000, 1'b0, -1, 0);
        preset.push_back(8'hA5);
        preset.push_back(8'h3C);
        run_packet(2, 2, 0, 16'hBEEF, 1'b0, -1, 0);
        run_packet(1, 0, 0, 16'($urandom), 1'b0, -1, 0);
        run_packet(3, 0, 0, 16'h0000, 1'b0, 11, 0);

        run_err(6, 0);
        run_err(1, 65);
        run_err(7, 3);
        run_err(2, 65);

        run_packet(2, 4, 0, 16'($urandom), 1'b0, -1, 140);
        run_packet(3, 0, 0, 16'h0000, 1'b0, -1, 0);

        for (int k = 0; k < 8; k++)
            run_packet(int'($urandom_range(1, 5)), int'($urandom_range(0, 10)), 0,
                       16'($urandom), 1'b1, -1, 0);

        run_packet(1, 64, 0, 16'($urandom), 1'b1, -1, 0);
        run_packet(2, 64, 2, 16'($urandom), 1'b1, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
